// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, LEGv8 branch decode and next-PC select with boot/run/halt control
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        negFlag,
  input  logic        zeroFlag,
  input  logic        overflowFlag,
  input  logic        carry_outFlag,
  input  logic [63:0] Db,
  input  logic        stall,
  output logic [63:0] pc,
  output logic [63:0] zerothSum,
  output logic        branch_taken,
  output logic        fetch_valid,
  output logic        halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state;
  logic        is_b, is_bl, is_cbz, is_bcond;
  logic        cond_true;
  logic [63:0] offset;
  logic [63:0] target;
  logic        halt_cond;

  assign is_b     = (instruction[31:26] == 6'b000101);
  assign is_bl    = (instruction[31:26] == 6'b100101);
  assign is_cbz   = (instruction[31:24] == 8'b10110100);
  assign is_bcond = (instruction[31:24] == 8'b01010100);

  always_comb begin
    cond_true = 1'b0;
    case (instruction[3:0])
      4'b0000: cond_true = zeroFlag;
      4'b0001: cond_true = !zeroFlag;
      4'b0010: cond_true = carry_outFlag;
      4'b0011: cond_true = !carry_outFlag;
      4'b0100: cond_true = negFlag;
      4'b0101: cond_true = !negFlag;
      4'b0110: cond_true = overflowFlag;
      4'b0111: cond_true = !overflowFlag;
      4'b1000: cond_true = carry_outFlag & !zeroFlag;
      4'b1001: cond_true = !(carry_outFlag & !zeroFlag);
      4'b1010: cond_true = (negFlag == overflowFlag);
      4'b1011: cond_true = (negFlag != overflowFlag);
      4'b1100: cond_true = !zeroFlag & (negFlag == overflowFlag);
      4'b1101: cond_true = !(!zeroFlag & (negFlag == overflowFlag));
      default: cond_true = 1'b1;
    endcase
  end

  // B/BL carry a 26-bit word offset; CBZ/B.cond carry a 19-bit one in [23:5]
  always_comb begin
    if (is_b || is_bl)
      offset = {{36{instruction[25]}}, instruction[25:0], 2'b00};
    else
      offset = {{43{instruction[23]}}, instruction[23:5], 2'b00};
  end

  assign target    = pc + offset;
  assign zerothSum = pc + 64'd4;

  assign branch_taken = (state == RUN) &&
                        (is_b || is_bl || (is_cbz && (Db == 64'd0)) || (is_bcond && cond_true));

  // A taken branch to itself can never make progress, so it parks the unit
  assign halt_cond = branch_taken && (target == pc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (halt_cond) begin
            state       <= HALT;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end else if (!stall) begin
            pc <= branch_taken ? target : zerothSum;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a behavioural next-PC model
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        rst_w;
  logic [31:0] instruction;
  logic        negFlag, zeroFlag, overflowFlag, carry_outFlag;
  logic [63:0] Db;
  logic        stall;
  logic [63:0] pc, zerothSum;
  logic        branch_taken, fetch_valid, halted;

  logic [31:0] nop_w;
  logic [63:0] w_pc, w_zs;
  logic        w_bt, w_fv, w_halted;

  int checks;
  int errors;

  logic [63:0] m_pc;
  bit          m_boot, m_run, m_halt;

  localparam logic [31:0] NOP = 32'h8B00_0000;

  fetch_unit #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .negFlag(negFlag), .zeroFlag(zeroFlag), .overflowFlag(overflowFlag),
    .carry_outFlag(carry_outFlag), .Db(Db), .stall(stall),
    .pc(pc), .zerothSum(zerothSum), .branch_taken(branch_taken),
    .fetch_valid(fetch_valid), .halted(halted)
  );

  fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clk(clk), .reset(rst_w), .instruction(nop_w),
    .negFlag(1'b0), .zeroFlag(1'b0), .overflowFlag(1'b0),
    .carry_outFlag(1'b0), .Db(64'd0), .stall(1'b0),
    .pc(w_pc), .zerothSum(w_zs), .branch_taken(w_bt),
    .fetch_valid(w_fv), .halted(w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_cond(input logic [3:0] c, input bit n, input bit z, input bit cf, input bit v);
    bit r;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !r : r;
  endfunction

  // Returns whether the instruction redirects, and where to, from the architectural rules
  task automatic model_branch(input logic [31:0] ins, input logic [63:0] db, input logic [3:0] nzcv,
                              input logic [63:0] cur, output bit taken, output logic [63:0] tgt);
    longint words;
    taken = 1'b0;
    words = 0;
    if (ins[31:26] == 6'b000101 || ins[31:26] == 6'b100101) begin
      words = longint'(ins[25:0]);
      if (ins[25]) words = words - (longint'(1) << 26);
      taken = 1'b1;
    end else if (ins[31:24] == 8'hB4 || ins[31:24] == 8'h54) begin
      words = longint'(ins[23:5]);
      if (ins[23]) words = words - (longint'(1) << 19);
      if (ins[31:24] == 8'hB4) taken = (db == 0);
      else taken = model_cond(ins[3:0], nzcv[3], nzcv[2], nzcv[1], nzcv[0]);
    end
    tgt = cur + 64'(words * 4);
  endtask

  task automatic cyc(input logic [31:0] ins, input logic [3:0] nzcv, input logic [63:0] db, input logic st);
    bit          tk;
    logic [63:0] tg;
    instruction = ins;
    {negFlag, zeroFlag, carry_outFlag, overflowFlag} = nzcv;
    Db = db;
    stall = st;
    #2;
    model_branch(ins, db, nzcv, m_pc, tk, tg);
    tk = tk && m_run;
    check_eq("branch_taken", 64'(branch_taken), 64'(tk));
    check_eq("zerothSum", zerothSum, m_pc + 64'd4);
    check_eq("fetch_valid", 64'(fetch_valid), 64'(m_run));
    check_eq("halted", 64'(halted), 64'(m_halt));
    @(posedge clk);
    if (m_boot) begin
      m_boot = 0;
      m_run  = 1;
    end else if (m_run) begin
      if (tk && tg == m_pc) begin
        m_run  = 0;
        m_halt = 1;
      end else if (!st) begin
        m_pc = tk ? tg : m_pc + 64'd4;
      end
    end
    #1;
    check_eq("pc", pc, m_pc);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    m_pc = 64'h0; m_boot = 1; m_run = 0; m_halt = 0;
    check_eq("rst_pc", pc, 64'h0);
    check_eq("rst_zs", zerothSum, 64'h4);
    check_eq("rst_fv", 64'(fetch_valid), 64'h0);
    check_eq("rst_halted", 64'(halted), 64'h0);
    check_eq("rst_bt", 64'(branch_taken), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] mk_b(input bit link, input int off);
    logic [25:0] imm;
    imm = 26'(off);
    return {link ? 6'b100101 : 6'b000101, imm};
  endfunction

  function automatic logic [31:0] mk_cbz(input int off);
    logic [18:0] imm;
    imm = 19'(off);
    return {8'hB4, imm, 5'd3};
  endfunction

  function automatic logic [31:0] mk_bc(input int off, input logic [3:0] c);
    logic [18:0] imm;
    imm = 19'(off);
    return {8'h54, imm, 1'b0, c};
  endfunction

  initial begin
    int halt_cycles;
    checks = 0;
    errors = 0;
    nop_w = NOP;
    rst_w = 1'b0;
    instruction = NOP;
    {negFlag, zeroFlag, carry_outFlag, overflowFlag} = 4'b0;
    Db = 0;
    stall = 0;
    reset = 1'b1;
    #2;
    do_reset();
    rst_w = 1'b1;

    cyc(NOP, 4'b0, 64'd0, 1'b0);
    check_eq("wrap_boot_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("wrap_zs", w_zs, 64'h0);
    cyc(NOP, 4'b0, 64'd0, 1'b0);
    check_eq("wrap_pc", w_pc, 64'h0);
    cyc(NOP, 4'b0, 64'd0, 1'b0);
    check_eq("nop_pc8", pc, 64'h8);
    cyc(mk_b(0, 3), 4'b0, 64'd0, 1'b0);
    check_eq("b_fwd", pc, 64'h14);
    cyc(mk_b(0, -2), 4'b0, 64'd0, 1'b0);
    check_eq("b_back", pc, 64'hC);
    cyc(mk_bc(4, 4'b1011), 4'b1000, 64'd0, 1'b0);
    check_eq("blt_taken", pc, 64'h1C);
    cyc(mk_bc(4, 4'b1011), 4'b1001, 64'd0, 1'b0);
    check_eq("blt_not", pc, 64'h20);
    cyc(mk_bc(4, 4'b1100), 4'b0100, 64'd0, 1'b0);
    check_eq("bgt_not", pc, 64'h24);
    cyc(mk_bc(4, 4'b1110), 4'b0000, 64'd0, 1'b0);
    check_eq("bal", pc, 64'h34);
    cyc(mk_cbz(2), 4'b0, 64'd0, 1'b0);
    check_eq("cbz_taken", pc, 64'h3C);
    cyc(mk_cbz(2), 4'b0, 64'd5, 1'b0);
    check_eq("cbz_not", pc, 64'h40);
    cyc(mk_b(1, 5), 4'b0, 64'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(NOP, 4'b0, 64'd0, 1'b1);
    check_eq("stall_hold", pc, 64'h54);
    cyc(NOP, 4'b0, 64'd0, 1'b0);
    cyc(mk_b(0, 0), 4'b0, 64'd0, 1'b1);
    check_eq("halt_enter", 64'(halted), 64'h1);
    for (int i = 0; i < 3; i++) cyc(mk_b(0, 7), 4'b0, 64'd0, 1'b0);
    check_eq("halt_pc", pc, 64'h58);
    do_reset();

    halt_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      int          off;
      logic [63:0] db;
      off = $urandom_range(16) - 8;
      case ($urandom_range(4))
        0: ins = NOP;
        1: ins = mk_b($urandom_range(1), off);
        2: ins = mk_cbz(off);
        3: ins = mk_bc(off, 4'($urandom));
        default: ins = {8'h54, 19'($urandom), 1'b0, 4'($urandom)};
      endcase
      db = ($urandom_range(1) == 0) ? 64'd0 : {$urandom, $urandom};
      cyc(ins, 4'($urandom), db, ($urandom_range(4) == 0));
      if (m_halt) halt_cycles++;
      if (halt_cycles >= 2) begin
        halt_cycles = 0;
        do_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
